// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a two-stage pixel pipeline.
// Sync, blank, frame_start and rgb all leave the block two cycles after the counters.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 4,
  parameter int COL_W    = 10,
  parameter int ROW_W    = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              scale,
  input  logic [3*CW-1:0]   solid_rgb,
  input  logic [3*CW-1:0]   data_in,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic              rd_en,
  output logic [3*CW-1:0]   rgb,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic              frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int H_BEG   = H_SYNC + H_BP;
  localparam int H_END   = H_BEG + H_ACTIVE;
  localparam int V_BEG   = V_SYNC + V_BP;
  localparam int V_END   = V_BEG + V_ACTIVE;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] hc;
  logic [VW-1:0] vc;

  always_ff @(posedge clk) begin
    if (rst) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_LAST) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + VW'(1);
    end else begin
      hc <= hc + HW'(1);
    end
  end

  logic          vis0;
  logic [HW-1:0] x0;
  logic [VW-1:0] y0;
  logic          hs0;
  logic          vs0;

  always_comb begin
    vis0 = (int'(hc) >= H_BEG) && (int'(hc) < H_END) &&
           (int'(vc) >= V_BEG) && (int'(vc) < V_END);
    x0   = hc - HW'(H_BEG);
    y0   = vc - VW'(V_BEG);
    hs0  = (int'(hc) < H_SYNC) ? HS_POL : ~HS_POL;
    vs0  = (int'(vc) < V_SYNC) ? VS_POL : ~VS_POL;
  end

  logic            vis1;
  logic [HW-1:0]   x1;
  logic [VW-1:0]   y1;
  logic [1:0]      mode1;
  logic [3*CW-1:0] solid1;
  logic            hs1;
  logic            vs1;

  // Addresses hold outside the visible area so the RAM sees a stable address.
  always_ff @(posedge clk) begin
    if (rst) begin
      col    <= '0;
      row    <= '0;
      rd_en  <= 1'b0;
      vis1   <= 1'b0;
      x1     <= '0;
      y1     <= '0;
      mode1  <= 2'b00;
      solid1 <= '0;
      hs1    <= ~HS_POL;
      vs1    <= ~VS_POL;
    end else begin
      if (vis0) begin
        col <= scale ? COL_W'(x0 >> 1) : COL_W'(x0);
        row <= scale ? ROW_W'(y0 >> 1) : ROW_W'(y0);
      end
      rd_en  <= vis0 && (mode == 2'b00);
      vis1   <= vis0;
      x1     <= x0;
      y1     <= y0;
      mode1  <= mode;
      solid1 <= solid_rgb;
      hs1    <= hs0;
      vs1    <= vs0;
    end
  end

  logic [2:0]      bar;
  logic [3*CW-1:0] pix;

  always_comb begin
    bar = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (int'(x1) >= i * BAR_W) bar = 3'(i);
    end
    pix = '0;
    if (vis1) begin
      case (mode1)
        2'b01:   pix = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
        2'b10:   pix = solid1;
        2'b11:   pix = {(3*CW){x1[3] ^ y1[3]}};
        default: pix = '0;
      endcase
    end
  end

  logic [3*CW-1:0] rgb_q;
  logic            fb_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q       <= '0;
      fb_sel      <= 1'b0;
      blank       <= 1'b1;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      rgb_q       <= pix;
      fb_sel      <= rd_en;
      blank       <= ~vis1;
      hsync       <= hs1;
      vsync       <= vs1;
      frame_start <= vis1 && (x1 == '0) && (y1 == '0);
    end
  end

  // RAM data arrives one cycle after rd_en, i.e. in the same cycle as the
  // stage-2 outputs, so framebuffer pixels bypass the rgb register.
  assign rgb = fb_sel ? data_in : rgb_q;

endmodule
